// File: rtl/sc_life_pkg.sv
// Shared definitions for the life-loss controller: state encodings and default timing.
package sc_life_pkg;

   localparam int ST_W = 3;

   typedef enum logic [ST_W-1:0] {
      ST_ARMED    = 3'b000,
      ST_PULSE    = 3'b001,
      ST_CHECK    = 3'b010,
      ST_INVULN   = 3'b011,
      ST_GAMEOVER = 3'b100
   } state_t;

   localparam int DEF_INVULN_TICKS = 25000000;
   localparam int DEF_BLINK_TICKS  = 3125000;
   localparam int DEF_CNT_WIDTH    = 25;

   // Bits needed to count 0 .. ticks-1, never less than one.
   function automatic int ticks_width(input int ticks);
      return (ticks <= 2) ? 1 : $clog2(ticks);
   endfunction

endpackage

// File: rtl/sc_cc_tick_counter.sv
// Up-counter with synchronous clear and enable; flags and wraps at TERMINAL.
module sc_cc_tick_counter #(
   parameter int WIDTH    = 4,
   parameter int TERMINAL = 7
) (
   input  logic i_clk_sys,
   input  logic i_rst_b,
   input  logic i_clr,
   input  logic i_en,
   output logic o_tc
);

   localparam logic [WIDTH-1:0] TC_VAL = WIDTH'(TERMINAL);

   logic [WIDTH-1:0] r_count;
   logic             w_tc;

   assign w_tc = (r_count == TC_VAL);
   assign o_tc = w_tc;

   always_ff @(posedge i_clk_sys or negedge i_rst_b) begin
      if (!i_rst_b) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_en) begin
         r_count <= w_tc ? '0 : r_count + 1'b1;
      end
   end

endmodule

// File: rtl/sc_ctrl_life_loss.sv
// Life-loss controller: one subtract pulse per collision hit, invulnerability window
// with sprite blink, and game-over detection from the lives register.
//
//   state     | meaning
//   ARMED     | waiting for a collision falling edge
//   PULSE     | subtract-life strobe low for this one cycle
//   CHECK     | lives register updated; decide INVULN or GAMEOVER
//   INVULN    | invulnerability window, hits ignored, sprite blinks
//   GAMEOVER  | no lives left; wait for gameStart
module sc_ctrl_life_loss
   import sc_life_pkg::*;
#(
   parameter int INVULN_TICKS = DEF_INVULN_TICKS,
   parameter int BLINK_TICKS  = DEF_BLINK_TICKS,
   parameter int CNT_WIDTH    = DEF_CNT_WIDTH
) (
   input  logic            CtrlLIFE_LOSS_CLOCK_50,
   input  logic            CtrlLIFE_LOSS_RESET_InLow,
   input  logic            CtrlLIFE_LOSS_gameStart_InLow,
   input  logic            CtrlLIFE_LOSS_collision_InLow,
   input  logic            CtrlLIFE_LOSS_sinVidas_InLow,
   output logic            CtrlLIFE_LOSS_substractLife_OutLow,
   output logic            CtrlLIFE_LOSS_invulnerable_OutHigh,
   output logic            CtrlLIFE_LOSS_blink_OutHigh,
   output logic            CtrlLIFE_LOSS_gameOver_OutHigh,
   output logic [ST_W-1:0] CtrlLIFE_LOSS_state_OutBUS
);

   localparam int BLK_W = ticks_width(BLINK_TICKS);

   state_t r_state;
   state_t w_state_nxt;
   logic   r_col_prev;
   logic   r_blink_phase;
   logic   w_hit_edge;
   logic   w_start;
   logic   w_cnt_clr;
   logic   w_cnt_en;
   logic   w_inv_tc;
   logic   w_blk_tc;
   logic   w_sub_n;
   logic   w_invuln;
   logic   w_blink;
   logic   w_game_over;

   assign w_start    = ~CtrlLIFE_LOSS_gameStart_InLow;
   assign w_hit_edge = r_col_prev & ~CtrlLIFE_LOSS_collision_InLow;
   assign w_cnt_en   = (r_state == ST_INVULN);
   assign w_cnt_clr  = (r_state != ST_INVULN) | w_start;

   sc_cc_tick_counter #(
      .WIDTH    (CNT_WIDTH),
      .TERMINAL (INVULN_TICKS - 1)
   ) u_invuln_cnt (
      .i_clk_sys (CtrlLIFE_LOSS_CLOCK_50),
      .i_rst_b   (CtrlLIFE_LOSS_RESET_InLow),
      .i_clr     (w_cnt_clr),
      .i_en      (w_cnt_en),
      .o_tc      (w_inv_tc)
   );

   sc_cc_tick_counter #(
      .WIDTH    (BLK_W),
      .TERMINAL (BLINK_TICKS - 1)
   ) u_blink_cnt (
      .i_clk_sys (CtrlLIFE_LOSS_CLOCK_50),
      .i_rst_b   (CtrlLIFE_LOSS_RESET_InLow),
      .i_clr     (w_cnt_clr),
      .i_en      (w_cnt_en),
      .o_tc      (w_blk_tc)
   );

   always_ff @(posedge CtrlLIFE_LOSS_CLOCK_50 or negedge CtrlLIFE_LOSS_RESET_InLow) begin
      if (!CtrlLIFE_LOSS_RESET_InLow) begin
         r_state       <= ST_GAMEOVER;
         r_col_prev    <= 1'b1;
         r_blink_phase <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_col_prev <= CtrlLIFE_LOSS_collision_InLow;
         // Phase 0 shows the sprite, so blink starts high on window entry.
         if (w_cnt_clr) begin
            r_blink_phase <= 1'b0;
         end else if (w_blk_tc) begin
            r_blink_phase <= ~r_blink_phase;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_sub_n     = 1'b1;
      w_invuln    = 1'b0;
      w_blink     = 1'b0;
      w_game_over = 1'b0;

      unique case (r_state)
         ST_ARMED: begin
            // Check lives before accepting a hit so the register cannot wrap below zero.
            if (!CtrlLIFE_LOSS_sinVidas_InLow) begin
               w_state_nxt = ST_GAMEOVER;
            end else if (w_hit_edge) begin
               w_state_nxt = ST_PULSE;
            end
         end
         ST_PULSE: begin
            w_sub_n     = 1'b0;
            w_state_nxt = ST_CHECK;
         end
         ST_CHECK: begin
            w_state_nxt = CtrlLIFE_LOSS_sinVidas_InLow ? ST_INVULN : ST_GAMEOVER;
         end
         ST_INVULN: begin
            w_invuln = 1'b1;
            w_blink  = ~r_blink_phase;
            if (w_inv_tc) begin
               w_state_nxt = ST_ARMED;
            end
         end
         ST_GAMEOVER: begin
            w_game_over = 1'b1;
         end
         default: begin
            w_state_nxt = ST_GAMEOVER;
         end
      endcase

      if (w_start) begin
         w_state_nxt = ST_ARMED;
      end
   end

   assign CtrlLIFE_LOSS_substractLife_OutLow = w_sub_n;
   assign CtrlLIFE_LOSS_invulnerable_OutHigh = w_invuln;
   assign CtrlLIFE_LOSS_blink_OutHigh        = w_blink;
   assign CtrlLIFE_LOSS_gameOver_OutHigh     = w_game_over;
   assign CtrlLIFE_LOSS_state_OutBUS         = r_state;

endmodule
